// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage alignment unit: op/state encodings
// and big-endian byte-lane helpers.
package mem_access_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  function automatic logic is_load(input logic [2:0] op);
    return op <= OP_LBU;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic m;
    m = 1'b0;
    case (op)
      OP_LW, OP_SW:          m = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH:  m = off[0];
      default:               m = 1'b0;
    endcase
    return m;
  endfunction

  // Offset 0 is the most significant byte.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LW:   r = word;
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'b0, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'b0, b};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  op,
                                             input logic [31:0] data);
    logic [31:0] w;
    w = word;
    case (op)
      OP_SB: begin
        case (off)
          2'd0:    w[31:24] = data[7:0];
          2'd1:    w[23:16] = data[7:0];
          2'd2:    w[15:8]  = data[7:0];
          default: w[7:0]   = data[7:0];
        endcase
      end
      OP_SH: begin
        if (off[1]) w[15:0]  = data[15:0];
        else        w[31:16] = data[15:0];
      end
      OP_SW:   w = data;
      default: w = word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Combinational byte-lane datapath: load extract/extend and store merge.
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  op,
  input  logic [31:0] word,
  input  logic [31:0] data,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  assign ext    = lane_extract(word, off, op);
  assign merged = lane_merge(word, off, op, data);

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store alignment unit; sub-word stores run as a two-cycle
// read-modify-write against the word-addressed data memory.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W+1:0] baddr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              misalign,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);

  state_e            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_off;
  logic [2:0]        lat_op;
  logic [31:0]       lat_wdata;
  logic [31:0]       lat_rdata;

  logic              rmw;
  logic              mis;
  logic              sub_st;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        lane_off;
  logic [2:0]        lane_op;
  logic [31:0]       lane_word;
  logic [31:0]       lane_ext;
  logic [31:0]       lane_merged;

  assign rmw    = (state == ST_RMW_WR);
  assign waddr  = baddr[ADDR_W+1:2];
  assign mis    = is_misaligned(op, baddr[1:0]);
  assign sub_st = (op == OP_SH) || (op == OP_SB);

  // One lane unit serves both phases: live inputs in IDLE, latched ones in RMW_WR.
  assign lane_off  = rmw ? lat_off   : baddr[1:0];
  assign lane_op   = rmw ? lat_op    : op;
  assign lane_word = rmw ? lat_rdata : dm_rdata;

  mem_lane u_lane (
    .off    (lane_off),
    .op     (lane_op),
    .word   (lane_word),
    .data   (lat_wdata),
    .ext    (lane_ext),
    .merged (lane_merged)
  );

  always_comb begin
    rdata    = 32'b0;
    done     = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
    dm_addr  = '0;
    dm_rd    = 1'b0;
    dm_wr    = 1'b0;
    dm_wdata = 32'b0;
    if (rst) begin
      if (rmw) begin
        dm_wr    = 1'b1;
        dm_addr  = lat_addr;
        dm_wdata = lane_merged;
        done     = 1'b1;
      end else if (req) begin
        if (mis) begin
          misalign = 1'b1;
          done     = 1'b1;
        end else if (is_load(op)) begin
          dm_rd   = 1'b1;
          dm_addr = waddr;
          rdata   = lane_ext;
          done    = 1'b1;
        end else if (op == OP_SW) begin
          dm_wr    = 1'b1;
          dm_addr  = waddr;
          dm_wdata = wdata;
          done     = 1'b1;
        end else begin
          dm_rd   = 1'b1;
          dm_addr = waddr;
          stall   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_addr  <= '0;
      lat_off   <= 2'b0;
      lat_op    <= 3'b0;
      lat_wdata <= 32'b0;
      lat_rdata <= 32'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !mis && sub_st) begin
            lat_addr  <= waddr;
            lat_off   <= baddr[1:0];
            lat_op    <= op;
            lat_wdata <= wdata;
            lat_rdata <= dm_rdata;
            state     <= ST_RMW_WR;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access with a behavioural memory and reference model.
module tb_mem_access;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [8:0]  baddr = 9'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done, stall, misalign;
  logic [6:0]  dm_addr;
  logic        dm_rd, dm_wr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  exp_t        comp_q[$];
  logic        stall_q[$];
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .baddr(baddr), .wdata(wdata),
    .rdata(rdata), .done(done), .stall(stall), .misalign(misalign),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr];
  always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on big-endian lanes.
  function automatic logic ref_mis(input int o, input int off);
    if (o == 0 || o == 5) return off != 0;
    if (o == 1 || o == 2 || o == 6) return (off % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int o);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - off))) & 32'hFF;
    h = (w >> (16 * (1 - off / 2))) & 32'hFFFF;
    case (o)
      0: return w;
      1: return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      2: return h;
      3: return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
      4: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input int off, input int o,
                                            input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (o == 5) return d;
    if (o == 6) sh = 16 * (1 - off / 2);
    else        sh = 8 * (3 - off);
    mask = ((o == 6) ? 32'hFFFF : 32'hFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Called one time unit after a rising edge; returns one unit after the op's last edge.
  task automatic issue(input int o, input int ba, input logic [31:0] d);
    int   off, wa;
    logic m, sub;
    exp_t e;
    off = ba % 4;
    wa  = ba / 4;
    m   = ref_mis(o, off);
    sub = !m && (o == 6 || o == 7);
    e.mis   = m;
    e.rdata = (!m && o <= 4) ? ref_load(ref_mem[wa], off, o) : 32'h0;
    if (!m && o >= 5) ref_mem[wa] = ref_store(ref_mem[wa], off, o, d);
    comp_q.push_back(e);
    stall_q.push_back(sub);
    if (sub) stall_q.push_back(1'b0);
    op    = o[2:0];
    baddr = ba[8:0];
    wdata = d;
    req   = 1'b1;
    @(posedge clk);
    if (sub) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT completes or stalls.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (req) begin
        if (stall_q.size() == 0) begin
          errors++;
          $display("FAIL stall_q_underflow at %0t", $time);
        end else begin
          logic s;
          s = stall_q.pop_front();
          chk("stall", {31'b0, stall}, {31'b0, s});
          if (s) chk("rmw_read_no_write", {30'b0, dm_wr, done}, 32'h0);
        end
      end else begin
        chk("idle_outputs", {26'b0, done, stall, misalign, dm_rd, dm_wr, |rdata}, 32'h0);
      end
      if (done) begin
        if (comp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at %0t", $time);
        end else begin
          exp_t e;
          e = comp_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[4] = 32'h8123_45F6;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

    req = 1'b1; op = 3'd7; baddr = 9'h011; wdata = 32'hAA;
    @(negedge clk);
    chk("reset_outputs", {25'b0, done, stall, misalign, dm_rd, dm_wr, |rdata, |dm_wdata}, 32'h0);
    chk("reset_dm_addr", {25'b0, dm_addr}, 32'h0);
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(0, 'h010, 32'h0);
    issue(3, 'h010, 32'h0);
    issue(4, 'h013, 32'h0);
    issue(1, 'h012, 32'h0);
    issue(1, 'h010, 32'h0);
    issue(7, 'h011, 32'hAA);
    chk("sb_mem4", mem[4], 32'h81AA_45F6);
    idle(1);
    issue(6, 'h013, 32'h1234);
    issue(5, 'h012, 32'hDEAD_BEEF);
    chk("mis_no_write", mem[4], 32'h81AA_45F6);
    issue(7, 'h010, 32'h11);
    issue(7, 'h013, 32'h22);
    chk("sb_pair_mem4", mem[4], 32'h11AA_4522);
    issue(0, 'h010, 32'h0);
    idle(1);

    // Reset asserted in the read cycle of a sub-word store.
    mon_en = 1'b0;
    op = 3'd7; baddr = 9'h020; wdata = 32'h5A; req = 1'b1;
    #2;
    chk("rst_sb_stall", {31'b0, stall}, 32'h1);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", {26'b0, done, stall, misalign, dm_rd, dm_wr, |dm_wdata}, 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_outputs", {26'b0, done, stall, misalign, dm_rd, dm_wr, |rdata}, 32'h0);
    chk("rst_mem_unchanged", mem[8], ref_mem[8]);
    @(posedge clk); #1;
    mon_en = 1'b1;
    issue(0, 'h020, 32'h0);

    for (int n = 0; n < 300; n++) begin
      int o, ba;
      o  = $urandom_range(0, 7);
      ba = $urandom_range(0, 31);
      issue(o, ba, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    chk("comp_q_empty", comp_q.size(), 32'h0);
    chk("stall_q_empty", stall_q.size(), 32'h0);
    for (int i = 0; i < 128; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage load/store alignment unit sitting between the MEM pipeline stage and the 128×32 word-addressed data memory `dm`.
- Translates MIPS load/store ops (LW, LH, LHU, LB, LBU, SW, SH, SB) on byte addresses into word accesses.
- Sign/zero-extends sub-word loads.
- Performs sub-word stores as a two-cycle read-modify-write, holding the pipeline with `stall`.
- Flags misaligned accesses.

## Interface
- ADDR_W, 7, word-address width; byte address is ADDR_W+2 bits.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- req  in  1  MEM stage holds a valid memory op this cycle.
- op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB.
- baddr  in  ADDR_W+2  byte address; [1:0] is the byte offset.
- wdata  in  32  store data, right-justified for SH/SB.
- rdata  out  32  extended load result, valid when `done` and the op is a load.
- done  out  1  op completes this cycle.
- stall  out  1  freeze the MEM stage; inputs must be held.
- misalign  out  1  address exception, one-cycle pulse.
- dm_addr  out  ADDR_W  word address to `dm`.
- dm_rd  out  1  read enable to `dm`.
- dm_wr  out  1  write enable to `dm`.
- dm_wdata  out  32  write data to `dm`.
- dm_rdata  in  32  combinational read data from `dm`.

## Operation
- Byte order is big-endian: offset 0 maps to bits [31:24], offset 3 maps to [7:0]. Halfword offset 0 maps to [31:16], offset 2 maps to [15:0].
- Misalignment:
  - LW/SW with baddr[1:0]≠0 is misaligned.
  - LH/LHU/SH with baddr[0]=1 is misaligned.
  - Response: `misalign`=1 and `done`=1 in the same cycle, dm_rd=dm_wr=0, no state change.
- FSM states IDLE, RMW_WR.
- IDLE with req=0: all outputs 0.
- IDLE, aligned load: dm_rd=1, dm_addr=baddr[ADDR_W+1:2]. The lane is selected from dm_rdata and extended (LH/LB sign-extend, LHU/LBU zero-extend, LW pass-through). `done`=1, `stall`=0. Stays in IDLE.
- IDLE, SW aligned: dm_wr=1, dm_wdata=wdata, `done`=1. Stays in IDLE.
- IDLE, SH/SB aligned:
  - Drives dm_rd=1 and `stall`=1, `done`=0.
  - Latches word address, offset, op, wdata and dm_rdata into internal registers.
  - Moves to RMW_WR.
- RMW_WR:
  - Drives dm_wr=1 from latched values. dm_wdata is the latched read word with the selected byte/halfword lane replaced by wdata[7:0]/[15:0].
  - `done`=1, `stall`=0. Inputs are ignored.
  - Returns to IDLE unconditionally.
- rdata is 0 whenever `done`=0 or the completing op is a store.
- Reset (async, any state): FSM→IDLE, all latch registers→0, all outputs 0. A sub-word store interrupted between its two cycles never writes memory.

## Timing
- Loads, SW, misaligned ops: zero-latency, complete in the request cycle.
- SH/SB: two cycles.
  - Cycle N: stall=1, read.
  - Cycle N+1: write, done=1.
  - The pipeline re-presents the same op in N+1. It is ignored, and the next op is accepted in N+2.
- `stall` is never high for two consecutive cycles.
- Back-to-back SB to the same word: the second read sees the first write. `dm` writes at the N+1 edge, and the second op's read happens at N+2 or later.
- Reset values: done=0, stall=0, misalign=0, rdata=0, dm_rd=0, dm_wr=0, dm_addr=0, dm_wdata=0.

## Structure
- Shared package holds the op encodings (OP_LW..OP_SB), FSM state encodings, and the byte-lane helpers: lane extract and lane merge functions.
- One sub-module, `mem_lane`: combinational extract/extend and merge on (offset, op, word, data). Used for both the load path and the RMW merge.
- Top: FSM, latch registers, `dm` port muxing.

## Test plan
- Reset, then LW at baddr 0x010 with mem[4]=0x8123_45F6 → done=1, rdata=0x812345F6, stall=0.
- Same word:
  - LB offset 0 → 0xFFFFFF81.
  - LBU offset 3 → 0x000000F6.
  - LH offset 2 → 0x000045F6.
  - LH offset 0 → 0xFFFF8123.
- SB wdata 0xAA at baddr 0x011 → cycle N stall=1, dm_wr=0. Cycle N+1 dm_wr=1 with dm_wdata=0x81AA45F6, then mem[4]=0x81AA45F6.
- SH at baddr 0x013 → misalign=1, done=1, no write. SW at 0x012 → misalign=1.
- Two consecutive SB to word 4, offsets 0 (0x11) and 3 (0x22) → mem[4]=0x11AA4522, and `stall` pattern 1,0,1,0.
- rst pulled low during cycle N of an SB → no dm_wr, FSM IDLE, outputs 0, memory unchanged.
